// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared types and constants for the dual-motor PWM driver
package motor_pkg;

    localparam int SPEED_W = 14;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } ch_state_e;

endpackage

// File: rtl/motor_pwm_channel.sv
// rtl/motor_pwm_channel.sv - one H-bridge channel: ramp, reversal dead interval, IN1/IN2 encode
module motor_pwm_channel
    import motor_pkg::*;
#(
    parameter int PWM_PERIOD   = 10000,
    parameter int RAMP_STEP    = 500,
    parameter int DEAD_PERIODS = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [SPEED_W-1:0] cnt_i,
    input  logic               pe_i,
    input  logic [SPEED_W-1:0] speed_i,
    input  logic               dir_i,
    output logic               in1_o,
    output logic               in2_o,
    output logic [SPEED_W-1:0] duty_o,
    output logic               dead_o
);

    localparam int DC_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
    localparam logic [SPEED_W:0]  PERIOD_X  = (SPEED_W + 1)'(PWM_PERIOD);
    localparam logic [SPEED_W:0]  RAMP_X    = (SPEED_W + 1)'(RAMP_STEP);
    localparam logic [DC_W-1:0]   DEAD_LAST = DC_W'(DEAD_PERIODS - 1);

    ch_state_e          state_q;
    logic               cur_dir_q;
    logic [SPEED_W-1:0] duty_q;
    logic [DC_W-1:0]    dead_cnt_q;
    logic               in1_q;
    logic               in2_q;

    logic [SPEED_W:0]   target_x;
    logic [SPEED_W:0]   duty_x;
    logic [SPEED_W:0]   ramp_x;
    logic [SPEED_W-1:0] duty_d;
    logic               pwm;

    // One extra bit keeps duty+step and target+step from wrapping near full scale.
    always_comb begin
        duty_x   = {1'b0, duty_q};
        target_x = ({1'b0, speed_i} > PERIOD_X) ? PERIOD_X : {1'b0, speed_i};
        ramp_x   = target_x;
        if (target_x > duty_x + RAMP_X) begin
            ramp_x = duty_x + RAMP_X;
        end else if (duty_x > target_x + RAMP_X) begin
            ramp_x = duty_x - RAMP_X;
        end
        duty_d = ramp_x[SPEED_W-1:0];
    end

    assign pwm = (state_q == ST_RUN) && (cnt_i < duty_q);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            cur_dir_q  <= DIR_FWD;
            duty_q     <= '0;
            dead_cnt_q <= '0;
            in1_q      <= 1'b0;
            in2_q      <= 1'b0;
        end else begin
            in1_q <= en_i && pwm && (cur_dir_q == DIR_FWD);
            in2_q <= en_i && pwm && (cur_dir_q == DIR_REV);
            if (!en_i) begin
                state_q    <= ST_IDLE;
                duty_q     <= '0;
                dead_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q   <= ST_RUN;
                        cur_dir_q <= dir_i;
                        duty_q    <= '0;
                    end
                    ST_RUN: begin
                        if (pe_i) begin
                            if (dir_i != cur_dir_q) begin
                                state_q    <= ST_DEAD;
                                duty_q     <= '0;
                                dead_cnt_q <= '0;
                            end else begin
                                duty_q <= duty_d;
                            end
                        end
                    end
                    ST_DEAD: begin
                        // Direction is re-sampled only when the full interval has elapsed.
                        if (pe_i) begin
                            if (dead_cnt_q == DEAD_LAST) begin
                                state_q   <= ST_RUN;
                                cur_dir_q <= dir_i;
                                duty_q    <= '0;
                            end else begin
                                dead_cnt_q <= dead_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        duty_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign in1_o  = in1_q;
    assign in2_o  = in2_q;
    assign duty_o = duty_q;
    assign dead_o = (state_q == ST_DEAD);

endmodule

// File: rtl/motor_pwm_driver.sv
// rtl/motor_pwm_driver.sv - dual H-bridge PWM driver with shared period counter
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int PWM_PERIOD   = 10000,
    parameter int RAMP_STEP    = 500,
    parameter int DEAD_PERIODS = 2
) (
    input  logic               clk_50M,
    input  logic               reset,
    input  logic               en,
    input  logic [SPEED_W-1:0] speed_l,
    input  logic               dir_l,
    input  logic [SPEED_W-1:0] speed_r,
    input  logic               dir_r,
    output logic               ain1,
    output logic               ain2,
    output logic               bin1,
    output logic               bin2,
    output logic [SPEED_W-1:0] duty_l,
    output logic [SPEED_W-1:0] duty_r,
    output logic               dead_l,
    output logic               dead_r
);

    localparam logic [SPEED_W-1:0] CNT_LAST = SPEED_W'(PWM_PERIOD - 1);

    logic [SPEED_W-1:0] cnt_q;
    logic               pe;

    assign pe = (cnt_q == CNT_LAST);

    always_ff @(posedge clk_50M) begin
        if (reset || !en) begin
            cnt_q <= '0;
        end else if (pe) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    motor_pwm_channel #(
        .PWM_PERIOD  (PWM_PERIOD),
        .RAMP_STEP   (RAMP_STEP),
        .DEAD_PERIODS(DEAD_PERIODS)
    ) u_left (
        .clk_i  (clk_50M),
        .reset_i(reset),
        .en_i   (en),
        .cnt_i  (cnt_q),
        .pe_i   (pe),
        .speed_i(speed_l),
        .dir_i  (dir_l),
        .in1_o  (ain1),
        .in2_o  (ain2),
        .duty_o (duty_l),
        .dead_o (dead_l)
    );

    motor_pwm_channel #(
        .PWM_PERIOD  (PWM_PERIOD),
        .RAMP_STEP   (RAMP_STEP),
        .DEAD_PERIODS(DEAD_PERIODS)
    ) u_right (
        .clk_i  (clk_50M),
        .reset_i(reset),
        .en_i   (en),
        .cnt_i  (cnt_q),
        .pe_i   (pe),
        .speed_i(speed_r),
        .dir_i  (dir_r),
        .in1_o  (bin1),
        .in2_o  (bin2),
        .duty_o (duty_r),
        .dead_o (dead_r)
    );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb/tb_motor_pwm_driver.sv - directed self-checking bench for motor_pwm_driver
module tb_motor_pwm_driver;
    import motor_pkg::*;

    logic        clk_50M = 1'b0;
    logic        reset;
    logic        en;
    logic [13:0] speed_l;
    logic        dir_l;
    logic [13:0] speed_r;
    logic        dir_r;
    logic        ain1, ain2, bin1, bin2;
    logic [13:0] duty_l, duty_r;
    logic        dead_l, dead_r;

    int checks   = 0;
    int failures = 0;
    int c_a1, c_a2, c_b1, c_b2;

    motor_pwm_driver #(
        .PWM_PERIOD  (100),
        .RAMP_STEP   (20),
        .DEAD_PERIODS(2)
    ) dut (
        .clk_50M(clk_50M),
        .reset  (reset),
        .en     (en),
        .speed_l(speed_l),
        .dir_l  (dir_l),
        .speed_r(speed_r),
        .dir_r  (dir_r),
        .ain1   (ain1),
        .ain2   (ain2),
        .bin1   (bin1),
        .bin2   (bin2),
        .duty_l (duty_l),
        .duty_r (duty_r),
        .dead_l (dead_l),
        .dead_r (dead_r)
    );

    always #5 clk_50M = ~clk_50M;

    always @(negedge clk_50M) begin
        checks++;
        assert (!((ain1 && ain2) || (bin1 && bin2))) else begin
            failures++;
            $error("FAIL shoot_through observed a=%b%b b=%b%b expected no pair both high", ain1, ain2, bin1, bin2);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    task automatic clear_counts();
        c_a1 = 0; c_a2 = 0; c_b1 = 0; c_b2 = 0;
    endtask

    task automatic run_count(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1);
            c_a1 += int'(ain1);
            c_a2 += int'(ain2);
            c_b1 += int'(bin1);
            c_b2 += int'(bin2);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0;
        speed_l = 14'd0; dir_l = 1'b1; speed_r = 14'd0; dir_r = 1'b1;
        tick(2);
        chk("rst_ain", {ain1, ain2}, 0);
        chk("rst_bin", {bin1, bin2}, 0);
        chk("rst_duty_l", duty_l, 0);
        chk("rst_duty_r", duty_r, 0);
        chk("rst_dead", {dead_l, dead_r}, 0);
        chk("rst_cnt", dut.cnt_q, 0);
        chk("rst_state_l", dut.u_left.state_q, ST_IDLE);

        reset = 1'b0;
        tick(1);
        en = 1'b1; speed_l = 14'd50; dir_l = 1'b1;
        tick(1);
        chk("en_state_l", dut.u_left.state_q, ST_RUN);
        tick(98);
        chk("ramp0_l", duty_l, 0);
        tick(1);
        chk("ramp20_l", duty_l, 20);
        tick(100);
        chk("ramp40_l", duty_l, 40);
        tick(100);
        chk("ramp50_l", duty_l, 50);
        clear_counts();
        run_count(100);
        chk("settled_ain1_hi", c_a1, 50);
        chk("settled_ain2_hi", c_a2, 0);
        chk("settled_duty_l", duty_l, 50);

        clear_counts();
        run_count(20);
        speed_l = 14'd10;
        run_count(80);
        chk("midchg_width", c_a1, 50);
        chk("midchg_duty30", duty_l, 30);
        tick(100);
        chk("midchg_duty10", duty_l, 10);
        speed_l = 14'd50;
        tick(100);
        chk("reramp30", duty_l, 30);
        tick(100);
        chk("reramp50", duty_l, 50);

        dir_l = 1'b0;
        tick(99);
        chk("rev_pre_duty", duty_l, 50);
        chk("rev_pre_dead", dead_l, 0);
        tick(1);
        chk("rev_duty0", duty_l, 0);
        chk("rev_dead1", dead_l, 1);
        clear_counts();
        run_count(199);
        chk("dead_ain1", c_a1, 0);
        chk("dead_ain2", c_a2, 0);
        chk("dead_still", dead_l, 1);
        run_count(1);
        chk("dead_end", dead_l, 0);
        chk("dead_end_duty", duty_l, 0);
        tick(100);
        chk("rev_ramp20", duty_l, 20);
        clear_counts();
        run_count(100);
        chk("rev_ain2_hi", c_a2, 20);
        chk("rev_ain1_hi", c_a1, 0);
        chk("rev_ramp40", duty_l, 40);
        tick(100);
        chk("rev_ramp50", duty_l, 50);
        chk("right_idle_duty", duty_r, 0);

        speed_r = 14'd16000; dir_r = 1'b1;
        tick(400);
        chk("sat_ramp80", duty_r, 80);
        tick(100);
        chk("sat_duty100", duty_r, 100);
        clear_counts();
        run_count(100);
        chk("sat_bin1_hi", c_b1, 100);
        chk("sat_bin2_hi", c_b2, 0);
        speed_r = 14'd0;
        tick(100);
        chk("down80", duty_r, 80);
        tick(300);
        chk("down20", duty_r, 20);
        tick(100);
        chk("down0", duty_r, 0);
        clear_counts();
        run_count(100);
        chk("down_bin1_hi", c_b1, 0);

        dir_l = 1'b1;
        tick(99);
        chk("dead2_pre", dead_l, 0);
        tick(1);
        chk("dead2_flag", dead_l, 1);
        tick(10);
        en = 1'b0;
        tick(1);
        chk("dis_ain", {ain1, ain2}, 0);
        chk("dis_bin", {bin1, bin2}, 0);
        chk("dis_dead_l", dead_l, 0);
        chk("dis_duty_l", duty_l, 0);
        chk("dis_cnt", dut.cnt_q, 0);
        tick(3);
        en = 1'b1; dir_l = 1'b0; speed_r = 14'd80;
        tick(1);
        chk("reen_dead", dead_l, 0);
        chk("reen_dir", dut.u_left.cur_dir_q, DIR_REV);
        tick(98);
        chk("reen_duty0", duty_l, 0);
        tick(1);
        chk("reen_duty20", duty_l, 20);
        chk("reen_r20", duty_r, 20);
        chk("reen_nodead", dead_l, 0);
        tick(200);
        chk("reen_duty50", duty_l, 50);
        clear_counts();
        run_count(100);
        chk("reen_ain2_hi", c_a2, 50);
        chk("reen_ain1_hi", c_a1, 0);
        chk("reen_r80", duty_r, 80);

        tick(30);
        reset = 1'b1;
        tick(1);
        chk("midrst_ain", {ain1, ain2}, 0);
        chk("midrst_bin", {bin1, bin2}, 0);
        chk("midrst_duty", {duty_l, duty_r}, 0);
        chk("midrst_cnt", dut.cnt_q, 0);
        chk("midrst_state_l", dut.u_left.state_q, ST_IDLE);
        chk("midrst_state_r", dut.u_right.state_q, ST_IDLE);
        chk("midrst_dir_l", dut.u_left.cur_dir_q, DIR_FWD);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
